// File: rtl/disp_pkg.sv
// disp_pkg: shared constants, FSM state type and digit-count helper for the display path
package disp_pkg;
  localparam int DIGIT_W = 4;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  // smallest digit count whose decimal range covers every BIN_W-bit value
  function automatic int min_digits(input int bin_w);
    longint unsigned lim = (64'd1 << bin_w) - 64'd1;
    longint unsigned p = 64'd1;
    int d = 0;
    while (p <= lim) begin
      p = p * 64'd10;
      d++;
    end
    return d;
  endfunction
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: one double-dabble correction cell, adds 3 to a digit of 5 or more
module bcd_add3
  import disp_pkg::*;
(
  input  logic [DIGIT_W-1:0] d_i,
  output logic [DIGIT_W-1:0] d_o
);
  assign d_o = d_i >= DIGIT_W'(5) ? d_i + DIGIT_W'(3) : d_i;
endmodule

// File: rtl/score_bcd_enc.sv
// score_bcd_enc: serial binary-to-BCD converter with registered digits and leading-zero enables
module score_bcd_enc
  import disp_pkg::*;
#(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [BIN_W-1:0]            bin_in,
  input  logic                        blank_lz,
  output logic                        busy,
  output logic                        done,
  output logic [DIGIT_W*DIGITS-1:0]   digit_out,
  output logic [DIGITS-1:0]           digit_en
);
  localparam int CW = BIN_W > 1 ? $clog2(BIN_W) : 1;
  if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
    $error("score_bcd_enc: DIGITS too small for BIN_W");
  end
  state_t                      state_q;
  logic [BIN_W-1:0]            sh_q, sh_d;
  logic [DIGIT_W*DIGITS-1:0]   acc_q, acc_d, adj;
  logic [CW-1:0]               cnt_q;
  logic                        blank_q, busy_q, done_q, nz;
  logic [DIGIT_W*DIGITS-1:0]   digit_out_q;
  logic [DIGITS-1:0]           digit_en_q, en_d;
  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .d_i(acc_q[DIGIT_W*i +: DIGIT_W]),
      .d_o(adj[DIGIT_W*i +: DIGIT_W])
    );
  end
  // the top accumulator bit falls off the shift; it is always zero for in-range values
  assign {acc_d, sh_d} = {adj, sh_q} << 1;
  always_comb begin
    en_d = '0;
    nz = 1'b0;
    for (int i = DIGITS-1; i >= 0; i--) begin
      nz = nz | (acc_d[DIGIT_W*i +: DIGIT_W] != '0);
      en_d[i] = !blank_q | nz | (i == 0);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      blank_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      digit_out_q <= '0;
      digit_en_q  <= DIGITS'(1);
    end else if (start && state_q != SHIFT) begin
      state_q <= SHIFT;
      sh_q    <= bin_in;
      acc_q   <= '0;
      cnt_q   <= CW'(BIN_W-1);
      blank_q <= blank_lz;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else if (state_q == SHIFT) begin
      sh_q  <= sh_d;
      acc_q <= acc_d;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == '0) begin
        state_q     <= DONE;
        busy_q      <= 1'b0;
        done_q      <= 1'b1;
        digit_out_q <= acc_d;
        digit_en_q  <= en_d;
      end
    end else begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end
  end
  assign busy      = busy_q;
  assign done      = done_q;
  assign digit_out = digit_out_q;
  assign digit_en  = digit_en_q;
endmodule

// File: tb/tb_score_bcd_enc.sv
// tb_score_bcd_enc: directed scoreboard bench for score_bcd_enc
module tb_score_bcd_enc;
  typedef struct packed {logic [15:0] d; logic [3:0] en;} exp_t;
  logic        clk = 1'b0;
  logic        rst_n, start, blank_lz, busy, done;
  logic [9:0]  bin_in;
  logic [15:0] digit_out;
  logic [3:0]  digit_en;
  exp_t        q[$];
  exp_t        last, mon_e;
  int          tests = 0, fails = 0, dones = 0, pushes = 0, dones_at_rst;

  always #5 clk = ~clk;

  score_bcd_enc dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in), .blank_lz(blank_lz),
    .busy(busy), .done(done), .digit_out(digit_out), .digit_en(digit_en)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // decimal digits by division; enables from the count of significant digits
  function automatic exp_t model(input int v, input logic b);
    exp_t r;
    int n = v, nd = 0;
    for (int i = 0; i < 4; i++) begin
      r.d[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    n = v;
    do begin nd++; n = n / 10; end while (n > 0);
    r.en = b ? 4'((1 << nd) - 1) : 4'hF;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) last = '{d: 16'h0000, en: 4'b0001};
    else if (done) begin
      dones++;
      check("busy_low_on_done", busy, 0);
      check("done_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        check("digit_out", digit_out, mon_e.d);
        check("digit_en", digit_en, mon_e.en);
        last = mon_e;
      end
    end
  end

  task automatic push(input int v, input logic b);
    q.push_back(model(v, b));
    pushes++;
  endtask

  task automatic start_conv(input int v, input logic b);
    start = 1'b1; bin_in = 10'(v); blank_lz = b;
    push(v, b);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int lat = 0;
    while (!done && lat < 40) begin
      check({tag, "_busy"}, busy, 1);
      check({tag, "_hold_d"}, digit_out, last.d);
      check({tag, "_hold_en"}, digit_en, last.en);
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_d"}, digit_out, 16'h0000);
    check({tag, "_en"}, digit_en, 4'b0001);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; bin_in = '0; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    start_conv(0, 1'b1);
    wait_done("v0", 10);
    @(negedge clk);
    start_conv(1023, 1'b1);
    wait_done("v1023", 10);
    start_conv(305, 1'b1);
    wait_done("v305_b1", 10);
    start_conv(305, 1'b0);
    wait_done("v305_b0", 10);
    @(negedge clk);
    start_conv(999, 1'b1);
    repeat (3) begin
      check("v999_early_busy", busy, 1);
      check("v999_early_hold", digit_out, last.d);
      @(negedge clk);
    end
    start = 1'b1; bin_in = 10'd42;
    @(negedge clk);
    start = 1'b0;
    wait_done("v999", 6);
    repeat (15) @(negedge clk);
    check("single_done_999", dones, pushes);
    start = 1'b1; bin_in = 10'd7; blank_lz = 1'b1;
    push(7, 1'b1);
    push(58, 1'b1);
    @(negedge clk);
    bin_in = 10'd58;
    wait_done("b2b_7", 10);
    @(negedge clk);
    start = 1'b0;
    wait_done("b2b_58", 10);
    @(negedge clk);
    start_conv(512, 1'b1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset("abort");
    q.delete();
    pushes--;
    dones_at_rst = dones;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("no_done_after_abort", dones, dones_at_rst);
    start_conv(512, 1'b1);
    wait_done("v512", 10);
    repeat (3) @(negedge clk);
    check("all_done", dones, pushes);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
